// File: rtl/loom_mem_shadow_ctrl.sv
// Shadow-access controller: global byte address -> (channel, word, 32-bit lane) with RMW for wide memories.
// Optional: LOOM_SHADOW_DECODE_ERR_EN flags unmapped requests with rsp_err and a 0xDEADBEEF read pattern.

module loom_mem_shadow_dec #(
  parameter int          ADDR_W     = 16,
  parameter int          MEM_ADDR_W = 12,
  parameter int          MAX_W      = 64,
  parameter int          LANE_W     = 1,
  parameter logic [ADDR_W-1:0] BASE = '0,
  parameter int unsigned DEPTH      = 1,
  parameter int unsigned WIDTH      = 32
) (
  input  logic [ADDR_W-1:0]     addr,
  output logic                  hit,
  output logic [MEM_ADDR_W-1:0] word,
  output logic [LANE_W-1:0]     lane,
  output logic                  wide,
  output logic [MAX_W-1:0]      mask
);
  localparam logic [63:0] STRIDE = 64'(4 * ((WIDTH + 31) / 32));
  localparam logic [63:0] LIMIT  = 64'(DEPTH) * STRIDE;
  localparam logic [MAX_W-1:0] MASK = (WIDTH >= MAX_W) ? '1
                                    : ((MAX_W'(1) << WIDTH) - MAX_W'(1));

  logic [63:0] a, off;

  assign a    = 64'(addr) & ~64'h3;
  assign off  = a - 64'(BASE);
  assign hit  = (a >= 64'(BASE)) && (off < LIMIT);
  assign word = MEM_ADDR_W'(off / STRIDE);
  assign lane = LANE_W'((off % STRIDE) >> 2);
  assign wide = (WIDTH > 32);
  assign mask = MASK;
endmodule

module loom_mem_shadow_ctrl #(
  parameter int NUM_MEMS   = 2,
  parameter int ADDR_W     = 16,
  parameter int MEM_ADDR_W = 12,
  parameter int MAX_W      = 64,
  parameter logic [NUM_MEMS*ADDR_W-1:0] MEM_BASE  = {16'h0400, 16'h0000},
  parameter logic [NUM_MEMS*32-1:0]     MEM_DEPTH = {32'd64, 32'd256},
  parameter logic [NUM_MEMS*32-1:0]     MEM_WIDTH = {32'd16, 32'd8}
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [31:0]               req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_err,
  output logic [MEM_ADDR_W-1:0]     mem_addr,
  output logic [MAX_W-1:0]          mem_wdata,
  output logic [NUM_MEMS-1:0]       mem_wen,
  output logic [NUM_MEMS-1:0]       mem_ren,
  input  logic [NUM_MEMS*MAX_W-1:0] mem_rdata
);
  localparam int NLANES = (MAX_W + 31) / 32;
  localparam int LANE_W = (NLANES > 1) ? $clog2(NLANES) : 1;
`ifdef LOOM_SHADOW_DECODE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

  typedef struct packed {
    logic                write;
    logic                wide;
    logic [31:0]         wdata;
    logic [NUM_MEMS-1:0] sel;
    logic [LANE_W-1:0]   lane;
    logic [MAX_W-1:0]    mask;
  } req_t;

  state_t state_q, state_d;
  req_t   req_q;
  logic   accept;

  logic [NUM_MEMS-1:0]                 ch_hit, ch_wide;
  logic [NUM_MEMS-1:0][MEM_ADDR_W-1:0] ch_word;
  logic [NUM_MEMS-1:0][LANE_W-1:0]     ch_lane;
  logic [NUM_MEMS-1:0][MAX_W-1:0]      ch_mask;

  logic                  dec_hit, dec_wide;
  logic [NUM_MEMS-1:0]   dec_sel;
  logic [MEM_ADDR_W-1:0] dec_word;
  logic [LANE_W-1:0]     dec_lane;
  logic [MAX_W-1:0]      dec_mask;

  logic [MEM_ADDR_W-1:0] mem_addr_q;
  logic [MAX_W-1:0]      mem_wdata_q, rd_raw, rd_word, merged;
  logic [LANE_W+4:0]     lane_sh;
  logic [31:0]           rsp_rdata_q, rd_lane;
  logic                  rsp_err_q;

  // One decoder per channel; the incoming address is decoded so the first strobe lands at T+1.
  for (genvar i = 0; i < NUM_MEMS; i++) begin : g_dec
    loom_mem_shadow_dec #(
      .ADDR_W(ADDR_W), .MEM_ADDR_W(MEM_ADDR_W), .MAX_W(MAX_W), .LANE_W(LANE_W),
      .BASE(MEM_BASE[i*ADDR_W +: ADDR_W]),
      .DEPTH(MEM_DEPTH[i*32 +: 32]),
      .WIDTH(MEM_WIDTH[i*32 +: 32])
    ) u_dec (
      .addr(req_addr), .hit(ch_hit[i]), .word(ch_word[i]),
      .lane(ch_lane[i]), .wide(ch_wide[i]), .mask(ch_mask[i])
    );
  end

  // Lowest-index channel wins on overlap: scan downward so index 0 overrides last.
  always_comb begin
    dec_sel  = '0;
    dec_word = '0;
    dec_lane = '0;
    dec_wide = 1'b0;
    dec_mask = '0;
    for (int i = NUM_MEMS - 1; i >= 0; i--) begin
      if (ch_hit[i]) begin
        dec_sel  = NUM_MEMS'(1) << i;
        dec_word = ch_word[i];
        dec_lane = ch_lane[i];
        dec_wide = ch_wide[i];
        dec_mask = ch_mask[i];
      end
    end
  end
  assign dec_hit = |ch_hit;
  assign accept  = req_valid & req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = !dec_hit ? RESP
                                   : (!req_write || dec_wide) ? RD : WR;
      RD:      state_d = CAP;
      CAP:     state_d = req_q.write ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE) & rst_n;
    rsp_valid = (state_q == RESP);
    mem_ren   = (state_q == RD) ? req_q.sel : '0;
    mem_wen   = (state_q == WR) ? req_q.sel : '0;
  end

  always_comb begin
    rd_raw = '0;
    for (int i = 0; i < NUM_MEMS; i++)
      if (req_q.sel[i]) rd_raw = mem_rdata[i*MAX_W +: MAX_W];
  end

  assign lane_sh = {req_q.lane, 5'b0};
  assign rd_word = rd_raw & req_q.mask;
  assign rd_lane = 32'(rd_word >> lane_sh);
  // Lanes past the channel width fall away under the mask.
  assign merged  = ((rd_word & ~(MAX_W'(32'hFFFF_FFFF) << lane_sh))
                    | (MAX_W'(req_q.wdata) << lane_sh)) & req_q.mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (accept) begin
      req_q <= '{write: req_write, wide: dec_wide, wdata: req_wdata,
                 sel: dec_sel, lane: dec_lane, mask: dec_mask};
      if (dec_hit) mem_addr_q <= dec_word;
      if (dec_hit && req_write && !dec_wide)
        mem_wdata_q <= MAX_W'(req_wdata) & dec_mask;
      rsp_rdata_q <= (!dec_hit && !req_write && ERR_EN) ? 32'hDEAD_BEEF : 32'h0;
      rsp_err_q   <= ERR_EN & !dec_hit;
    end else if (state_q == CAP) begin
      if (req_q.write) mem_wdata_q <= merged;
      else             rsp_rdata_q <= rd_lane;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_loom_mem_shadow_ctrl.sv
// Directed bench for loom_mem_shadow_ctrl: 3 memories (8b x256, 16b x64, 64b x32) behind a behavioural memory model.
module tb_loom_mem_shadow_ctrl;
  localparam int NUM_MEMS = 3, ADDR_W = 16, MEM_ADDR_W = 12, MAX_W = 64;
`ifdef LOOM_SHADOW_DECODE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [MAX_W-1:0] mem_wdata;
  logic [NUM_MEMS-1:0] mem_wen, mem_ren;
  logic [63:0] rd0 = '0, rd1 = '0, rd2 = '0;
  logic [NUM_MEMS*MAX_W-1:0] mem_rdata;

  always #5 clk = ~clk;

  loom_mem_shadow_ctrl #(
    .NUM_MEMS(NUM_MEMS), .ADDR_W(ADDR_W), .MEM_ADDR_W(MEM_ADDR_W), .MAX_W(MAX_W),
    .MEM_BASE({16'h0800, 16'h0400, 16'h0000}),
    .MEM_DEPTH({32'd32, 32'd64, 32'd256}),
    .MEM_WIDTH({32'd64, 32'd16, 32'd8})
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_ren(mem_ren),
    .mem_rdata(mem_rdata)
  );

  // Memory model: 1-cycle read latency, synchronous write.
  logic [7:0]  m0 [256];
  logic [15:0] m1 [64];
  logic [63:0] m2 [32];
  assign mem_rdata = {rd2, rd1, rd0};

  always @(posedge clk) begin
    if (mem_ren[0]) rd0 <= {56'd0, m0[mem_addr[7:0]]};
    if (mem_ren[1]) rd1 <= {48'd0, m1[mem_addr[5:0]]};
    if (mem_ren[2]) rd2 <= m2[mem_addr[4:0]];
    if (mem_wen[0]) m0[mem_addr[7:0]] = mem_wdata[7:0];
    if (mem_wen[1]) m1[mem_addr[5:0]] = mem_wdata[15:0];
    if (mem_wen[2]) m2[mem_addr[4:0]] = mem_wdata;
  end

  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic                  wr;
    logic [15:0]           addr;
    logic [31:0]           wdata;
    int                    lat;
    logic [2:0]            ren;
    logic [2:0]            wen;
    logic [MEM_ADDR_W-1:0] maddr;
    logic [63:0]           mwdata;
    logic [31:0]           rdata;
    logic                  err;
  } vec_t;

  // Observations of the last transaction.
  int o_lat, o_rcnt, o_wcnt;
  logic [2:0] o_ren, o_wen;
  logic o_multi, o_err;
  logic [MEM_ADDR_W-1:0] o_maddr;
  logic [63:0] o_mwdata;
  logic [31:0] o_rdata;

  task automatic run_req(input logic wr, input logic [15:0] addr, input logic [31:0] wd);
    o_lat = 0; o_rcnt = 0; o_wcnt = 0; o_ren = '0; o_wen = '0; o_multi = 1'b0;
    o_maddr = '0; o_mwdata = '0; o_rdata = '0; o_err = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 10 && o_lat == 0; k++) begin
      if (mem_ren != 0) begin o_ren |= mem_ren; o_rcnt++; o_maddr = mem_addr; end
      if (mem_wen != 0) begin o_wen |= mem_wen; o_wcnt++; o_maddr = mem_addr; o_mwdata = mem_wdata; end
      if ($countones(mem_ren | mem_wen) > 1) o_multi = 1'b1;
      if (rsp_valid) begin o_lat = k; o_rdata = rsp_rdata; o_err = rsp_err; end
      else @(negedge clk);
    end
  endtask

  task automatic ack(input string name);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({name, " ack {rsp_valid,req_ready}"}, 64'({rsp_valid, req_ready}), 64'b01);
  endtask

  vec_t vt[15];

  initial begin
    logic wen_seen;
    for (int i = 0; i < 256; i++) m0[i] = '0;
    for (int i = 0; i < 64; i++)  m1[i] = '0;
    for (int i = 0; i < 32; i++)  m2[i] = '0;
    m0[8'h10] = 8'hAB;
    m0[8'hFF] = 8'h77;
    m1[0]     = 16'hBEEF;
    m2[0]     = 64'hFFFF_FFFF_0000_0000;
    m2[5]     = 64'h1122_3344_5566_7788;
    m2[31]    = 64'hA5A5_A5A5_0F0F_0F0F;

    //            wr    addr     wdata          lat ren     wen     maddr   mwdata                   rdata                         err
    vt[0]  = '{1'b0, 16'h040, 32'h0,         3, 3'b001, 3'b000, 12'h010, 64'h0,                  32'h0000_00AB,                1'b0};
    vt[1]  = '{1'b1, 16'h4FC, 32'h1234_CAFE, 2, 3'b000, 3'b010, 12'h03F, 64'h0000_CAFE,          32'h0,                        1'b0};
    vt[2]  = '{1'b0, 16'h4FC, 32'h0,         3, 3'b010, 3'b000, 12'h03F, 64'h0,                  32'h0000_CAFE,                1'b0};
    vt[3]  = '{1'b1, 16'h82C, 32'hDEAD_BEEF, 4, 3'b100, 3'b100, 12'h005, 64'hDEADBEEF_55667788,  32'h0,                        1'b0};
    vt[4]  = '{1'b0, 16'h828, 32'h0,         3, 3'b100, 3'b000, 12'h005, 64'h0,                  32'h5566_7788,                1'b0};
    vt[5]  = '{1'b0, 16'h82C, 32'h0,         3, 3'b100, 3'b000, 12'h005, 64'h0,                  32'hDEAD_BEEF,                1'b0};
    vt[6]  = '{1'b0, 16'h700, 32'h0,         1, 3'b000, 3'b000, 12'h000, 64'h0,                  ERR_EN ? 32'hDEAD_BEEF : 32'h0, ERR_EN};
    vt[7]  = '{1'b1, 16'h900, 32'h1,         1, 3'b000, 3'b000, 12'h000, 64'h0,                  32'h0,                        ERR_EN};
    vt[8]  = '{1'b1, 16'h041, 32'hFFFF_FF5A, 2, 3'b000, 3'b001, 12'h010, 64'h5A,                 32'h0,                        1'b0};
    vt[9]  = '{1'b0, 16'h043, 32'h0,         3, 3'b001, 3'b000, 12'h010, 64'h0,                  32'h0000_005A,                1'b0};
    vt[10] = '{1'b0, 16'h3FC, 32'h0,         3, 3'b001, 3'b000, 12'h0FF, 64'h0,                  32'h0000_0077,                1'b0};
    vt[11] = '{1'b0, 16'h400, 32'h0,         3, 3'b010, 3'b000, 12'h000, 64'h0,                  32'h0000_BEEF,                1'b0};
    vt[12] = '{1'b0, 16'h8FC, 32'h0,         3, 3'b100, 3'b000, 12'h01F, 64'h0,                  32'hA5A5_A5A5,                1'b0};
    vt[13] = '{1'b1, 16'h800, 32'h0102_0304, 4, 3'b100, 3'b100, 12'h000, 64'hFFFFFFFF_01020304,  32'h0,                        1'b0};
    vt[14] = '{1'b0, 16'h800, 32'h0,         3, 3'b100, 3'b000, 12'h000, 64'h0,                  32'h0102_0304,                1'b0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset req_ready", 64'(req_ready), 64'h1);
    chk("reset rsp/strobes", 64'({rsp_valid, rsp_err, mem_wen, mem_ren}), 64'h0);
    chk("reset rsp_rdata", 64'(rsp_rdata), 64'h0);
    chk("reset mem_addr", 64'(mem_addr), 64'h0);
    chk("reset mem_wdata", mem_wdata, 64'h0);

    for (int v = 0; v < 15; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      run_req(vt[v].wr, vt[v].addr, vt[v].wdata);
      chk({nm, " latency"}, 64'(o_lat), 64'(vt[v].lat));
      chk({nm, " rsp_rdata"}, 64'(o_rdata), 64'(vt[v].rdata));
      chk({nm, " rsp_err"}, 64'(o_err), 64'(vt[v].err));
      chk({nm, " mem_ren"}, 64'(o_ren), 64'(vt[v].ren));
      chk({nm, " ren pulses"}, 64'(o_rcnt), (vt[v].ren != 0) ? 64'd1 : 64'd0);
      chk({nm, " mem_wen"}, 64'(o_wen), 64'(vt[v].wen));
      chk({nm, " wen pulses"}, 64'(o_wcnt), (vt[v].wen != 0) ? 64'd1 : 64'd0);
      chk({nm, " strobe one-hot"}, 64'(o_multi), 64'h0);
      if ((vt[v].ren | vt[v].wen) != 0) chk({nm, " mem_addr"}, 64'(o_maddr), 64'(vt[v].maddr));
      if (vt[v].wen != 0) chk({nm, " mem_wdata"}, o_mwdata, vt[v].mwdata);
      ack(nm);
    end

    // Response held under backpressure; a new request must not be taken.
    run_req(1'b0, 16'h828, 32'h0);
    chk("hold latency", 64'(o_lat), 64'd3);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h040;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("hold%0d valid/ready/strobe", c), 64'({rsp_valid, req_ready, mem_ren, mem_wen}), 64'b10_000_000);
      chk($sformatf("hold%0d rsp_rdata", c), 64'(rsp_rdata), 64'h5566_7788);
    end
    req_valid = 1'b0;
    ack("hold");

    // Reset lands in CAP of an RMW: no write may follow.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h800; req_wdata = 32'h1111_1111;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rmw T+1 mem_ren", 64'(mem_ren), 64'b100);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst ready/rsp/strobes", 64'({req_ready, rsp_valid, rsp_err, mem_wen, mem_ren}), 64'h0);
    chk("midrst rsp_rdata", 64'(rsp_rdata), 64'h0);
    chk("midrst mem_addr", 64'(mem_addr), 64'h0);
    chk("midrst mem_wdata", mem_wdata, 64'h0);
    wen_seen = 1'b0;
    repeat (2) begin @(negedge clk); wen_seen |= |mem_wen; end
    rst_n = 1'b1;
    #1;
    chk("post-reset req_ready", 64'(req_ready), 64'h1);
    repeat (4) begin @(negedge clk); wen_seen |= |mem_wen; end
    chk("no write after reset", 64'(wen_seen), 64'h0);
    chk("mem2[0] untouched", m2[0], 64'hFFFF_FFFF_0102_0304);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
